// File: rtl/data_access_unit.sv
// data_access_unit: pipeline-side initiator for the data port of the memory
// wrapper. Takes one load/store at a time, drives the MEM_* request until
// memValid2 completes it (or the timeout expires), then returns a registered
// valid/ready response. Misaligned and illegal-size requests never touch
// memory.
module data_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        MEM_CLK,
    input  logic        RST_N,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2,
    input  logic        memValid2
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0]  SZ_HALF = 2'd1;
    localparam logic [1:0]  SZ_WORD = 2'd2;
    localparam logic [1:0]  SZ_ILL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                mem_rden_q,  mem_rden_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q,   mem_din_d;
    logic [1:0]          mem_size_q,  mem_size_d;
    logic                mem_sign_q,  mem_sign_d;
    logic                we_q,        we_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic                req_bad;
    logic                timeout_hit;

    // Request is rejected when its size is illegal or the address is not naturally aligned.
    assign req_bad = (req_size == SZ_ILL)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // This ACCESS cycle without completion is the last one the timeout allows.
    assign timeout_hit = TO_EN && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

    // State and output registers; reset forces every output inactive at once.
    always_ff @(posedge MEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_rden_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_size_q  <= '0;
            mem_sign_q  <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_rden_q  <= mem_rden_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_size_q  <= mem_size_d;
            mem_sign_q  <= mem_sign_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition changes it.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_rden_d  = mem_rden_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_size_d  = mem_size_q;
        mem_sign_d  = mem_sign_q;
        we_d        = we_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mem_addr_d  = req_addr;
                    mem_din_d   = req_wdata;
                    mem_size_d  = req_size;
                    mem_sign_d  = req_unsigned;
                    we_d        = req_we;
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    if (req_bad) begin
                        // Rejected without any memory enable.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = ST_ACCESS;
                        mem_rden_d = ~req_we;
                        mem_we_d   = req_we;
                    end
                end
            end

            ST_ACCESS: begin
                if (memValid2) begin
                    // Completion wins over a timeout reached on the same edge.
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : MEM_DOUT2;
                    mem_rden_d  = 1'b0;
                    mem_we_d    = 1'b0;
                    cnt_d       = '0;
                end else if (timeout_hit) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    mem_rden_d  = 1'b0;
                    mem_we_d    = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                mem_rden_d  = 1'b0;
                mem_we_d    = 1'b0;
                cnt_d       = '0;
            end
        endcase
    end

    // Registered outputs.
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign MEM_RDEN2 = mem_rden_q;
    assign MEM_WE2   = mem_we_q;
    assign MEM_ADDR2 = mem_addr_q;
    assign MEM_DIN2  = mem_din_q;
    assign MEM_SIZE  = mem_size_q;
    assign MEM_SIGN  = mem_sign_q;

endmodule

// File: tb/tb_data_access_unit.sv
// Self-checking bench for data_access_unit: transaction-level reference model
// compared every cycle, directed scenarios with hand-computed expectations,
// then randomized traffic with a random memory responder and async resets.
module tb_data_access_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        MEM_RDEN2;
    logic        MEM_WE2;
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2 = '0;
    logic        memValid2 = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;

    data_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .MEM_CLK(clk), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
        .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2), .memValid2(memValid2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction phases) ----------------
    localparam int PH_IDLE = 0;
    localparam int PH_MEM  = 1;
    localparam int PH_RSP  = 2;

    int          m_phase;
    int          m_wait;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_size;
    logic        m_uns;
    logic [31:0] m_rdata;
    logic        m_err;

    function automatic bit is_bad(input logic [1:0] s, input logic [31:0] a);
        logic [1:0] lo;
        lo = a[1:0];
        return (s == 2'd3) || (s == 2'd1 && lo[0]) || (s == 2'd2 && lo != 2'b00);
    endfunction

    always @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            m_phase = PH_IDLE; m_wait = 0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_size = '0; m_uns = 1'b0;
            m_rdata = '0; m_err = 1'b0;
        end else begin
            case (m_phase)
                PH_IDLE: if (req_valid) begin
                    m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
                    m_size = req_size; m_uns = req_unsigned; m_wait = 0;
                    if (is_bad(req_size, req_addr)) begin
                        m_phase = PH_RSP; m_err = 1'b1; m_rdata = '0;
                    end else begin
                        m_phase = PH_MEM;
                    end
                end
                PH_MEM: begin
                    if (memValid2) begin
                        m_phase = PH_RSP; m_err = 1'b0;
                        m_rdata = m_we ? 32'd0 : MEM_DOUT2;
                    end else begin
                        m_wait++;
                        if (TO != 0 && m_wait == int'(TO)) begin
                            m_phase = PH_RSP; m_err = 1'b1; m_rdata = '0;
                        end
                    end
                end
                default: if (rsp_ready) m_phase = PH_IDLE;
            endcase
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(posedge clk) begin
        #1;
        if (chk_on && RST_N) begin
            chk("req_ready", 32'(req_ready), 32'(m_phase == PH_IDLE));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == PH_RSP));
            chk("mem_rden",  32'(MEM_RDEN2), 32'(m_phase == PH_MEM && !m_we));
            chk("mem_we",    32'(MEM_WE2),   32'(m_phase == PH_MEM && m_we));
            if (m_phase == PH_MEM) begin
                chk("mem_addr", MEM_ADDR2, m_addr);
                chk("mem_din",  MEM_DIN2,  m_wdata);
                chk("mem_size", 32'(MEM_SIZE), 32'(m_size));
                chk("mem_sign", 32'(MEM_SIGN), 32'(m_uns));
            end
            if (m_phase == PH_RSP) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err",   32'(rsp_err), 32'(m_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic we, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = wd;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        req_valid = 1'b0; rsp_ready = 1'b1; memValid2 = 1'b1;
        while (req_ready !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("wait_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic mid_reset();
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_rden", 32'(MEM_RDEN2), 32'd0);
        chk("async_rst_we",   32'(MEM_WE2),   32'd0);
        chk("async_rst_rspv", 32'(rsp_valid), 32'd0);
        chk("async_rst_rdy",  32'(req_ready), 32'd1);
        #1 RST_N = 1'b1;
    endtask

    int cnt;
    int r;
    logic [1:0]  bad_sz [3];
    logic [31:0] bad_ad [3];

    initial begin
        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        chk("rst_rden",      32'(MEM_RDEN2), 32'd0);
        chk("rst_we",        32'(MEM_WE2),   32'd0);
        chk("rst_addr",      MEM_ADDR2,      32'd0);
        chk("rst_din",       MEM_DIN2,       32'd0);
        RST_N = 1'b1;
        chk_on = 1'b1;
        step();

        // Word load, completion in the first ACCESS cycle.
        memValid2 = 1'b1; MEM_DOUT2 = 32'h1234_5678; rsp_ready = 1'b1;
        set_req(1'b0, 32'h0000_6004, 2'd2, 1'b0, 32'h0);
        step();
        req_valid = 1'b0;
        chk("ld_rden_c1", 32'(MEM_RDEN2), 32'd1);
        chk("ld_addr_c1", MEM_ADDR2, 32'h0000_6004);
        step();
        chk("ld_rden_c2", 32'(MEM_RDEN2), 32'd0);
        chk("ld_rspv_c2", 32'(rsp_valid), 32'd1);
        chk("ld_rdata",   rsp_rdata, 32'h1234_5678);
        chk("ld_err",     32'(rsp_err), 32'd0);
        step();
        chk("ld_done_rspv", 32'(rsp_valid), 32'd0);
        chk("ld_done_rdy",  32'(req_ready), 32'd1);

        // Store with 12 cycles of miss latency.
        memValid2 = 1'b0;
        set_req(1'b1, 32'h0000_7000, 2'd2, 1'b0, 32'hCAFE_F00D);
        step();
        req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 13; i++) begin
            if (MEM_WE2 && MEM_ADDR2 == 32'h7000 && MEM_DIN2 == 32'hCAFE_F00D) cnt++;
            if (i == 12) memValid2 = 1'b1;
            step();
        end
        chk("st_we_cycles", 32'(cnt), 32'd13);
        chk("st_we_off",    32'(MEM_WE2), 32'd0);
        chk("st_rspv",      32'(rsp_valid), 32'd1);
        chk("st_rdata",     rsp_rdata, 32'd0);
        chk("st_err",       32'(rsp_err), 32'd0);
        step();

        // Misaligned / illegal requests.
        bad_sz[0] = 2'd1; bad_ad[0] = 32'h6001;
        bad_sz[1] = 2'd2; bad_ad[1] = 32'h6002;
        bad_sz[2] = 2'd3; bad_ad[2] = 32'h6000;
        for (int i = 0; i < 3; i++) begin
            wait_idle();
            set_req(1'(i % 2), bad_ad[i], bad_sz[i], 1'b0, 32'h5555_AAAA);
            step();
            req_valid = 1'b0;
            chk("bad_rspv",  32'(rsp_valid), 32'd1);
            chk("bad_err",   32'(rsp_err),   32'd1);
            chk("bad_rdata", rsp_rdata,      32'd0);
            chk("bad_en",    32'({MEM_RDEN2, MEM_WE2}), 32'd0);
            step();
            chk("bad_en_after", 32'({MEM_RDEN2, MEM_WE2}), 32'd0);
        end

        // Timeout: no completion at all.
        wait_idle();
        memValid2 = 1'b0;
        set_req(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0);
        step();
        req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < int'(TO); i++) begin
            if (MEM_RDEN2) cnt++;
            step();
        end
        chk("to_rden_cycles", 32'(cnt), TO);
        chk("to_rden_off",    32'(MEM_RDEN2), 32'd0);
        chk("to_rspv",        32'(rsp_valid), 32'd1);
        chk("to_err",         32'(rsp_err), 32'd1);
        chk("to_rdata",       rsp_rdata, 32'd0);

        // Completion on the last allowed cycle beats the timeout.
        wait_idle();
        memValid2 = 1'b0;
        set_req(1'b0, 32'h0000_0104, 2'd1, 1'b1, 32'h0);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            if (i == int'(TO) - 1) begin
                memValid2 = 1'b1;
                MEM_DOUT2 = 32'h0000_A50F;
            end
            step();
        end
        chk("to_race_rspv",  32'(rsp_valid), 32'd1);
        chk("to_race_err",   32'(rsp_err), 32'd0);
        chk("to_race_rdata", rsp_rdata, 32'h0000_A50F);

        // Response backpressure with an ignored request pulse.
        wait_idle();
        rsp_ready = 1'b0; memValid2 = 1'b1; MEM_DOUT2 = 32'hDEAD_BEEF;
        set_req(1'b0, 32'h0000_6008, 2'd2, 1'b0, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv",  32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_rdy",   32'(req_ready), 32'd0);
            if (i == 2) set_req(1'b1, 32'h0000_6100, 2'd2, 1'b0, 32'h1111_2222);
            if (i == 3) req_valid = 1'b0;
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_idle_rdy", 32'(req_ready), 32'd1);
        chk("bp_no_store", 32'(MEM_WE2), 32'd0);
        set_req(1'b0, 32'h0001_0000, 2'd0, 1'b1, 32'h0);
        step();
        req_valid = 1'b0;
        chk("bp_next_rden", 32'(MEM_RDEN2), 32'd1);
        chk("bp_next_addr", MEM_ADDR2, 32'h0001_0000);

        // Async reset in the middle of an access.
        wait_idle();
        memValid2 = 1'b0;
        set_req(1'b0, 32'h0000_6010, 2'd2, 1'b0, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        chk("ar_rden_before", 32'(MEM_RDEN2), 32'd1);
        mid_reset();
        memValid2 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid) cnt++;
        end
        chk("ar_no_rsp", 32'(cnt), 32'd0);
        chk("ar_rdy",    32'(req_ready), 32'd1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (((c / 500) % 2) == 1) memValid2 = ($urandom_range(0, 19) == 0);
            else                      memValid2 = ($urandom_range(0, 2) == 0);
            MEM_DOUT2 = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = 1'($urandom_range(0, 1));
            req_we = 1'($urandom_range(0, 1));
            req_unsigned = 1'($urandom_range(0, 1));
            req_wdata = $urandom;
            r = int'($urandom_range(0, 9));
            req_size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 1) == 1) req_addr = 32'h0000_6000 + ($urandom & 32'h0000_0FFF);
            else                           req_addr = $urandom;
            if ($urandom_range(0, 3) != 0 && req_size == 2'd2) req_addr[1:0] = 2'b00;
            if ($urandom_range(0, 399) == 0) mid_reset();
            step();
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
